serial_word_source: RTL and testbench

Upstream stage for the serial sequence detectors (`mealy` and `moore`). It accepts parallel words over a valid/ready handshake and shifts them out one bit per clock onto the single-bit `din` line the detectors sample. Back-to-back words stream with no idle cycle between them, so detector patterns that span word boundaries are preserved.

---
 rtl/serial_word_source_pkg.sv | 18 +
 rtl/ser_shift_reg.sv | 45 ++++
 rtl/serial_word_source.sv | 146 ++++++++++++++
 tb/tb_serial_word_source.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_word_source_pkg.sv
// ----------------------------------------------------------------------------
// serial_word_source_pkg
//   Shared definitions for the serial word source:
//     - SER_DEFAULT_WIDTH : default number of data bits per word
//     - ser_state_t       : FSM state encodings SER_IDLE / SER_SHIFT / SER_PAR
//   SER_PAR is only reachable when the design is built with SER_PARITY_EN.
// ----------------------------------------------------------------------------
package serial_word_source_pkg;

    localparam int SER_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,   // no frame in flight
        SER_SHIFT = 2'd1,   // data bits on dout
        SER_PAR   = 2'd2    // parity bit on dout
    } ser_state_t;

endpackage : serial_word_source_pkg

// File: rtl/ser_shift_reg.sv
// ----------------------------------------------------------------------------
// ser_shift_reg
//   Loadable shift register with a fixed shift direction.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     load       : capture data (has priority over shift_en)
//     shift_en   : advance one position, filling with 0
//     data       : parallel load value
//     bit_out    : bit currently at the output end of the register
//   MSB_FIRST=1 shifts toward the MSB and outputs bit WIDTH-1;
//   MSB_FIRST=0 shifts toward the LSB and outputs bit 0.
//   Zero fill means the register drains to 0 once a frame has gone out,
//   so bit_out rests at 0 between frames with no extra gating.
// ----------------------------------------------------------------------------
module ser_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] data,
    output logic             bit_out
);

    logic [WIDTH-1:0] q;

    // NOTE: the register holds datapath contents, but it is still reset
    // because a reset mid-frame must drop dout to 0 immediately and never
    // let leftover bits of the aborted word leak out after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= data;
        end else if (shift_en) begin
            if (MSB_FIRST) q <= {q[WIDTH-2:0], 1'b0};
            else           q <= {1'b0, q[WIDTH-1:1]};
        end
    end

    assign bit_out = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule : ser_shift_reg

// File: rtl/serial_word_source.sv
// ----------------------------------------------------------------------------
// serial_word_source
//   Accepts parallel words over a valid/ready handshake and shifts them out
//   one bit per clock on dout. Back-to-back words stream with no idle cycle.
//   Parameters:
//     WIDTH     : data bits per word (2..32)
//     MSB_FIRST : 1 sends bit WIDTH-1 first, 0 sends bit 0 first
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     word_in    : parallel word, captured on the edge where valid && ready
//     word_valid : word_in is valid
//     word_ready : can take a word this cycle (from state/count only)
//     dout       : serial bit stream (registered)
//     dout_valid : dout carries a frame bit (registered)
//     word_done  : one-cycle pulse on the last bit of each frame (registered)
//   Build option:
//     SER_PARITY_EN : append an odd-parity bit after the data bits; the frame
//                     becomes WIDTH+1 bits and word_ready moves to the
//                     parity cycle.
// ----------------------------------------------------------------------------
module serial_word_source
    import serial_word_source_pkg::*;
#(
    parameter int WIDTH     = SER_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             word_done
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
`ifdef SER_PARITY_EN
    localparam int             FRAME_LEN = WIDTH + 1;
`else
    localparam int             FRAME_LEN = WIDTH;
`endif

    ser_state_t           state, state_nxt;
    logic [CW-1:0]        count, count_nxt;
    logic                 transfer;
    logic                 last_data;
    logic                 done_nxt;
    logic [FRAME_LEN-1:0] load_vec;

    assign last_data = (state == SER_SHIFT) && (count == LAST_BIT);
    assign transfer  = word_valid && word_ready;

`ifdef SER_PARITY_EN
    logic par_bit;
    // Odd parity: set when the data has an even number of ones.
    assign par_bit    = ~^word_in;
    // The parity bit sits at the far end of the frame so it leaves last.
    assign load_vec   = MSB_FIRST ? {word_in, par_bit} : {par_bit, word_in};
    assign word_ready = (state == SER_IDLE) || (state == SER_PAR);
`else
    assign load_vec   = word_in;
    assign word_ready = (state == SER_IDLE) || last_data;
`endif

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            SER_IDLE: begin
                if (transfer) begin
                    state_nxt = SER_SHIFT;
                    count_nxt = '0;
                end
            end
            SER_SHIFT: begin
                if (!last_data) begin
                    count_nxt = count + 1'b1;
`ifdef SER_PARITY_EN
                end else begin
                    state_nxt = SER_PAR;
                end
`else
                end else if (transfer) begin
                    state_nxt = SER_SHIFT;
                    count_nxt = '0;
                end else begin
                    state_nxt = SER_IDLE;
                    count_nxt = '0;
                end
`endif
            end
`ifdef SER_PARITY_EN
            SER_PAR: begin
                state_nxt = transfer ? SER_SHIFT : SER_IDLE;
                count_nxt = '0;
            end
`endif
            default: begin
                state_nxt = SER_IDLE;
                count_nxt = '0;
            end
        endcase
    end

    // word_done is registered, so it is armed when the next cycle will carry
    // the final bit of the frame.
`ifdef SER_PARITY_EN
    assign done_nxt = (state_nxt == SER_PAR);
`else
    assign done_nxt = (state_nxt == SER_SHIFT) && (count_nxt == LAST_BIT);
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SER_IDLE;
            count      <= '0;
            dout_valid <= 1'b0;
            word_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            dout_valid <= (state_nxt != SER_IDLE);
            word_done  <= done_nxt;
        end
    end

    // dout comes straight from the shift register's output flop.
    ser_shift_reg #(
        .WIDTH     (FRAME_LEN),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (transfer),
        .shift_en (state != SER_IDLE),
        .data     (load_vec),
        .bit_out  (dout)
    );

endmodule : serial_word_source

// File: tb/tb_serial_word_source.sv
// ----------------------------------------------------------------------------
// tb_serial_word_source
//   Drives two instances (MSB-first and LSB-first) with the same handshake
//   and compares every cycle against a queue-based model: each accepted word
//   appends its frame bits to a per-direction queue, and the head of the
//   queue is the bit expected on dout in the current cycle.
// ----------------------------------------------------------------------------
module tb_serial_word_source;

    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] word_in = '0;
    logic         word_valid = 1'b0;
    logic         word_ready, dout, dout_valid, word_done;
    logic         l_ready, l_dout, l_valid, l_done;

    serial_word_source #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready), .dout(dout), .dout_valid(dout_valid),
        .word_done(word_done)
    );

    serial_word_source #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
        .word_ready(l_ready), .dout(l_dout), .dout_valid(l_valid),
        .word_done(l_done)
    );

    always #5 clk = ~clk;

    bit q_m[$];
    bit q_l[$];
    bit xfer;
    int n_cmp = 0;
    int n_bad = 0;

    wire [7:0] obs = {word_ready, dout_valid, dout, word_done,
                      l_ready, l_valid, l_dout, l_done};

    // Expected {ready, valid, dout, done} for both instances this cycle.
    function automatic logic [7:0] exp_vec();
        logic bm, bl;
        bm = (q_m.size() > 0) ? q_m[0] : 1'b0;
        bl = (q_l.size() > 0) ? q_l[0] : 1'b0;
        return {q_m.size() <= 1, q_m.size() != 0, bm, q_m.size() == 1,
                q_l.size() <= 1, q_l.size() != 0, bl, q_l.size() == 1};
    endfunction

    // Drive one cycle from a negedge to the next, advancing the model.
    // Ready is high when idle or on the final bit of the frame.
    task automatic tick(input logic v, input logic [W-1:0] w);
        logic rdy;
        rdy = (q_m.size() <= 1);
        word_valid = v;
        word_in    = w;
        @(posedge clk);
        xfer = v && rdy && rst_n;
        if (q_m.size() > 0) begin
            void'(q_m.pop_front());
            void'(q_l.pop_front());
        end
        if (xfer) begin
            for (int i = 0; i < W; i++) begin
                q_m.push_back(w[W-1-i]);
                q_l.push_back(w[i]);
            end
`ifdef SER_PARITY_EN
            q_m.push_back(~^w);
            q_l.push_back(~^w);
`endif
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        q_m.delete();
        q_l.delete();
        for (int c = 0; c < 3; c++) begin
            tick(1'b1, 8'hA5);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL reset c%0d: got %b want %b", c, obs, exp_vec());
            end
        end
        rst_n = 1'b1;
        word_valid = 1'b0;
    endtask

    task automatic test_single(input logic [W-1:0] w, input logic [W-1:0] em,
                               input logic [W-1:0] el);
        int t = 0;
        int nm = 0, nl = 0;
        logic [W-1:0] sm = '0, sl = '0;
        do begin
            tick(1'b1, w);
            t++;
        end while (!xfer && t < 4 * FRAME);
        n_cmp++;
        if (!xfer) begin
            n_bad++;
            $display("FAIL single_%h timeout: got no transfer want transfer", w);
        end
        for (int c = 0; c < FRAME + 3; c++) begin
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL single_%h c%0d: got %b want %b", w, c, obs, exp_vec());
            end
            if (dout_valid && nm < W) begin sm = {sm[W-2:0], dout};   nm++; end
            if (l_valid    && nl < W) begin sl = {sl[W-2:0], l_dout}; nl++; end
            tick(1'b0, w);
        end
        n_cmp++;
        if ({sm, sl} !== {em, el}) begin
            n_bad++;
            $display("FAIL single_%h bits: got %h/%h want %h/%h", w, sm, sl, em, el);
        end
    endtask

    task automatic test_back_to_back();
`ifdef SER_PARITY_EN
        localparam logic [2*FRAME-1:0] EXP = 18'b0101_0101_1_1100_0011_1;
`else
        localparam logic [2*FRAME-1:0] EXP = 16'h55C3;
`endif
        logic [2*FRAME-1:0] seq = '0;
        int  run = 0, t = 0;
        bit  started = 0, ended = 0, second = 0;
        do begin
            tick(1'b1, 8'h55);
            t++;
        end while (!xfer && t < 4 * FRAME);
        for (int c = 0; c < 3 * FRAME; c++) begin
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL b2b c%0d: got %b want %b", c, obs, exp_vec());
            end
            if (dout_valid && !ended) begin
                started = 1;
                if (run < 2 * FRAME) seq = {seq[2*FRAME-2:0], dout};
                run++;
            end else if (started) begin
                ended = 1;
            end
            tick(!second, 8'hC3);
            if (xfer) second = 1;
        end
        n_cmp++;
        if (run != 2 * FRAME || seq !== EXP) begin
            n_bad++;
            $display("FAIL b2b stream: got %0d bits %b want %0d bits %b",
                     run, seq, 2 * FRAME, EXP);
        end
    endtask

    task automatic test_gap();
        logic [W-1:0] words [2];
        words[0] = 8'h3C;
        words[1] = 8'h96;
        for (int k = 0; k < 2; k++) begin
            int t = 0;
            do begin
                tick(1'b1, words[k]);
                t++;
            end while (!xfer && t < 4 * FRAME);
            for (int c = 0; c < FRAME + 5; c++) begin
                n_cmp++;
                if (obs !== exp_vec()) begin
                    n_bad++;
                    $display("FAIL gap w%0d c%0d: got %b want %b", k, c, obs, exp_vec());
                end
                tick(1'b0, words[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            int gap = $urandom_range(0, 3);
            int t = 0;
            logic [W-1:0] w = W'($urandom);
            for (int g = 0; g < gap; g++) begin
                n_cmp++;
                if (obs !== exp_vec()) begin
                    n_bad++;
                    $display("FAIL random n%0d gap: got %b want %b", n, obs, exp_vec());
                end
                tick(1'b0, w);
            end
            do begin
                n_cmp++;
                if (obs !== exp_vec()) begin
                    n_bad++;
                    $display("FAIL random n%0d w%h: got %b want %b", n, w, obs, exp_vec());
                end
                tick(1'b1, w);
                t++;
            end while (!xfer && t < 4 * FRAME);
            if (!xfer) begin
                n_cmp++;
                n_bad++;
                $display("FAIL random n%0d timeout: got no transfer want transfer", n);
            end
        end
        for (int c = 0; c < FRAME + 2; c++) begin
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL random drain c%0d: got %b want %b", c, obs, exp_vec());
            end
            tick(1'b0, '0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int t = 0;
        do begin
            tick(1'b1, 8'hFF);
            t++;
        end while (!xfer && t < 4 * FRAME);
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL rstmid bit%0d: got %b want %b", c, obs, exp_vec());
            end
            if (c < 2) tick(1'b0, 8'hFF);
        end
        // Third bit is on dout; assert reset between edges.
        #2;
        rst_n = 1'b0;
        q_m.delete();
        q_l.delete();
        #1;
        n_cmp++;
        if (obs !== 8'b1000_1000) begin
            n_bad++;
            $display("FAIL rstmid async: got %b want %b", obs, 8'b1000_1000);
        end
        @(negedge clk);
        tick(1'b1, 8'hFF);
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_bad++;
            $display("FAIL rstmid held: got %b want %b", obs, exp_vec());
        end
        rst_n = 1'b1;
        for (int c = 0; c < FRAME + 2; c++) begin
            tick(1'b0, 8'hFF);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL rstmid after c%0d: got %b want %b", c, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single(8'hAA, 8'hAA, 8'h55);
        test_single(8'h01, 8'h01, 8'h80);
        test_back_to_back();
        test_gap();
        test_random();
        test_reset_mid_frame();
`ifdef SER_PARITY_EN
        test_single(8'h07, 8'h07, 8'hE0);
        test_single(8'h03, 8'h03, 8'hC0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_serial_word_source
